// File: rtl/cline_mem_burst_adapter.sv
// cline_mem_burst_adapter
// Bridges whole-cache-line transactions from the eviction/write-back controller
// onto a narrow physical-memory bus. Writes are split into BEATS beats; read
// beats are assembled into one line and returned with a single mem_resp pulse.
module cline_mem_burst_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_action_stb,
    input  logic              mem_action_cyc,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              mem_retry,
    output logic              pmem_stb,
    output logic              pmem_cyc,
    output logic              pmem_we,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_ack,
    input  logic              pmem_retry
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BOFF  = $clog2(BEAT_W / 8);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] fill_next;
    logic              in_burst;

    assign in_burst = (state == WR_BURST) || (state == RD_BURST);

    // Line buffer with the current read beat merged in; used both to keep
    // collecting beats and to publish the finished line on the last ack.
    always_comb begin
        fill_next = line_buf;
        fill_next[int'(beat_cnt)*BEAT_W +: BEAT_W] = pmem_rdata;
    end

    // Bus-side outputs decode only from internal state, so nothing on the cache
    // side can ripple combinationally into the memory bus. Forced to zero
    // outside a burst so the bus is quiet while idle and during reset.
    assign pmem_stb     = in_burst;
    assign pmem_cyc     = in_burst;
    assign pmem_we      = (state == WR_BURST);
    assign pmem_address = in_burst ? (line_addr + (ADDR_W'(beat_cnt) << BOFF)) : '0;
    assign pmem_wdata   = in_burst ? line_buf[int'(beat_cnt)*BEAT_W +: BEAT_W] : '0;

    // Retry is only meaningful while a beat is outstanding; a simultaneous ack
    // wins, so the retry is hidden in that case.
    assign mem_retry = in_burst && pmem_retry && !pmem_ack;

    // A cache that dropped cyc mid-burst no longer wants the answer.
    assign mem_resp = (state == RESP) && mem_action_cyc;

    // Transaction FSM: accept a line, walk the beats, one response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            line_addr <= '0;
            line_buf  <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_action_stb && mem_action_cyc) begin
                        line_addr <= mem_address & ~OFF_MASK;
                        line_buf  <= mem_wdata;
                        beat_cnt  <= '0;
                        state     <= mem_write ? WR_BURST : RD_BURST;
                    end
                end
                WR_BURST, RD_BURST: begin
                    // Retry or wait state: hold everything so the beat is reissued.
                    if (pmem_ack) begin
                        if (state == RD_BURST) line_buf <= fill_next;
                        if (beat_cnt == LAST) begin
                            beat_cnt <= '0;
                            state    <= RESP;
                            if (state == RD_BURST) mem_rdata <= fill_next;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cline_mem_burst_adapter.sv
// Testbench for cline_mem_burst_adapter: a behavioural memory answers beats,
// expected beats and responses are queued when each request is issued.
module tb_cline_mem_burst_adapter;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_action_stb = 1'b0;
    logic              mem_action_cyc = 1'b0;
    logic              mem_write = 1'b0;
    logic [ADDR_W-1:0] mem_address = '0;
    logic [LINE_W-1:0] mem_wdata = '0;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              mem_retry;
    logic              pmem_stb;
    logic              pmem_cyc;
    logic              pmem_we;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata = '0;
    logic              pmem_ack = 1'b0;
    logic              pmem_retry = 1'b0;

    cline_mem_burst_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .mem_action_stb(mem_action_stb), .mem_action_cyc(mem_action_cyc),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_retry(mem_retry),
        .pmem_stb(pmem_stb), .pmem_cyc(pmem_cyc), .pmem_we(pmem_we),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_ack(pmem_ack), .pmem_retry(pmem_retry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BEAT_W-1:0] wdata;
    } beat_t;

    typedef struct {
        bit                wr;
        logic [LINE_W-1:0] rdata;
    } resp_t;

    beat_t beatq[$];
    resp_t respq[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int resp_cnt = 0;
    int resp_edge = 0;
    int retry_obs = 0;
    int retry_beat = -1;
    int retry_left = 0;
    int both_beat = -1;
    logic [LINE_W-1:0] last_read = '0;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    // Deterministic memory contents as a function of the beat address.
    function automatic logic [BEAT_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    // Memory model and beat scoreboard: checks the presented beat, then
    // decides ack / retry for the next edge.
    always @(negedge clk) begin
        automatic int bi;
        automatic beat_t e;
        pmem_ack   = 1'b0;
        pmem_retry = 1'b0;
        if (!rst && pmem_stb === 1'b1) begin
            bi = BEATS - beatq.size();
            checks++;
            if (beatq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat addr=%h we=%b", pmem_address, pmem_we);
            end else begin
                e = beatq[0];
                if (pmem_address !== e.addr || pmem_we !== e.we ||
                    (e.we && pmem_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL beat%0d got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                             bi, pmem_address, pmem_we, pmem_wdata, e.addr, e.we, e.wdata);
                end
                if (bi == retry_beat && retry_left > 0) begin
                    retry_left--;
                    pmem_retry = 1'b1;
                    #1;
                    checks++;
                    if (mem_retry !== 1'b1) begin
                        errors++;
                        $display("FAIL mem_retry_on_retry got %b want 1", mem_retry);
                    end else retry_obs++;
                end else begin
                    pmem_ack   = 1'b1;
                    pmem_retry = (bi == both_beat);
                    pmem_rdata = mem_fn(pmem_address);
                    void'(beatq.pop_front());
                    #1;
                    checks++;
                    if (mem_retry !== 1'b0) begin
                        errors++;
                        $display("FAIL mem_retry_on_ack got %b want 0", mem_retry);
                    end
                end
            end
        end
    end

    // Response scoreboard.
    always @(negedge clk) begin
        automatic resp_t r;
        if (mem_resp === 1'b1) begin
            resp_cnt++;
            resp_edge = edge_cnt;
            checks++;
            if (respq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp rdata=%h", mem_rdata);
            end else begin
                r = respq.pop_front();
                if (!r.wr && mem_rdata !== r.rdata) begin
                    errors++;
                    $display("FAIL resp_rdata got %h want %h", mem_rdata, r.rdata);
                end
            end
        end
    end

    task automatic push_req(input bit wr, input logic [ADDR_W-1:0] a,
                            input logic [LINE_W-1:0] wd, input bit want_resp);
        logic [ADDR_W-1:0] la;
        beat_t b;
        resp_t r;
        la = a & ~32'h1F;
        r.wr = wr;
        r.rdata = '0;
        for (int i = 0; i < BEATS; i++) begin
            b.addr  = la + 32'(i * 8);
            b.we    = wr;
            b.wdata = wd[i*BEAT_W +: BEAT_W];
            beatq.push_back(b);
            r.rdata[i*BEAT_W +: BEAT_W] = mem_fn(b.addr);
        end
        if (want_resp) respq.push_back(r);
        if (!wr) last_read = r.rdata;
    endtask

    // Drives one request; returns the edge count of the accepting edge.
    task automatic issue(input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] wd, input bit want_resp, output int acc);
        @(negedge clk);
        push_req(wr, a, wd, want_resp);
        mem_action_stb = 1'b1;
        mem_action_cyc = 1'b1;
        mem_write      = wr;
        mem_address    = a;
        mem_wdata      = wd;
        @(posedge clk);
        #1 acc = edge_cnt;
        @(negedge clk);
        // Garbage after accept must be ignored.
        mem_action_stb = 1'b0;
        mem_write      = ~wr;
        mem_address    = ~a;
        mem_wdata      = ~wd;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((beatq.size() != 0 || respq.size() != 0) && n < 300) begin
            @(posedge clk); #2; n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL wait_done timeout beats_left=%0d resps_left=%0d want 0 0",
                     beatq.size(), respq.size());
            beatq.delete();
            respq.delete();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_action_cyc = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({pmem_stb, pmem_cyc, pmem_we, mem_resp, mem_retry} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {pmem_stb, pmem_cyc, pmem_we, mem_resp, mem_retry});
        end
        checks++;
        if (pmem_address !== '0 || pmem_wdata !== '0 || mem_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%h wd=%h rd=%h want 0", pmem_address, pmem_wdata, mem_rdata);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_read();
        int acc, r0;
        r0 = resp_cnt;
        issue(1'b0, 32'h0000_1234, '0, 1'b1, acc);
        wait_done();
        // Accept at edge N; resp occupies the cycle after edge N+BEATS (cycle N+BEATS+1).
        checks++;
        if (resp_edge - acc !== BEATS) begin
            errors++;
            $display("FAIL read_latency got %0d want %0d", resp_edge - acc, BEATS);
        end
        checks++;
        if (resp_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL read_resp_count got %0d want 1", resp_cnt - r0);
        end
    endtask

    task automatic test_write();
        int acc, r0;
        logic [LINE_W-1:0] wd;
        logic [LINE_W-1:0] held;
        wd = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        held = last_read;
        r0 = resp_cnt;
        issue(1'b1, 32'h0000_8000, wd, 1'b1, acc);
        wait_done();
        checks++;
        if (resp_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL write_resp_count got %0d want 1", resp_cnt - r0);
        end
        checks++;
        if (mem_rdata !== held) begin
            errors++;
            $display("FAIL rdata_held got %h want %h", mem_rdata, held);
        end
    endtask

    task automatic test_retry();
        int acc, r0;
        r0 = retry_obs;
        retry_beat = 2;
        retry_left = 3;
        issue(1'b0, 32'h0001_0040, '0, 1'b1, acc);
        wait_done();
        retry_beat = -1;
        checks++;
        if (retry_obs - r0 !== 3) begin
            errors++;
            $display("FAIL retry_cycles got %0d want 3", retry_obs - r0);
        end
    endtask

    task automatic test_ack_retry_both();
        int acc, r0;
        r0 = resp_cnt;
        both_beat = 1;
        issue(1'b0, 32'h0002_00E0, '0, 1'b1, acc);
        wait_done();
        both_beat = -1;
        checks++;
        if (resp_edge - acc !== BEATS) begin
            errors++;
            $display("FAIL ack_wins_latency got %0d want %0d", resp_edge - acc, BEATS);
        end
    endtask

    task automatic test_cyc_drop();
        int acc, r0, n;
        r0 = resp_cnt;
        n = 0;
        issue(1'b1, 32'h0003_0000, {4{64'h0123_4567_89AB_CDEF}}, 1'b0, acc);
        while (beatq.size() > 2 && n < 50) begin @(posedge clk); #2; n++; end
        mem_action_cyc = 1'b0;
        wait_done();
        checks++;
        if (resp_cnt !== r0) begin
            errors++;
            $display("FAIL cyc_drop_resp got %0d want 0", resp_cnt - r0);
        end
        issue(1'b0, 32'h0003_1000, '0, 1'b1, acc);
        wait_done();
        checks++;
        if (resp_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL after_drop_resp got %0d want 1", resp_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        int acc, r0, n;
        n = 0;
        issue(1'b0, 32'h0000_4040, '0, 1'b1, acc);
        while (beatq.size() != 2 && n < 50) begin @(posedge clk); #2; n++; end
        r0 = resp_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if ({pmem_stb, pmem_cyc, pmem_we, mem_resp, mem_retry} !== 5'b0 ||
            pmem_address !== '0 || pmem_wdata !== '0 || mem_rdata !== '0) begin
            errors++;
            $display("FAIL reset_mid got ctl=%b a=%h wd=%h rd=%h want 0",
                     {pmem_stb, pmem_cyc, pmem_we, mem_resp, mem_retry},
                     pmem_address, pmem_wdata, mem_rdata);
        end
        beatq.delete();
        respq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_action_cyc = 1'b0;
        issue(1'b0, 32'h0005_5560, '0, 1'b1, acc);
        wait_done();
        checks++;
        if (resp_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL reset_mid_resume got %0d want 1", resp_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int acc, n;
        logic [LINE_W-1:0] wd;
        wd = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
        n = 0;
        issue(1'b0, 32'h0006_0020, '0, 1'b1, acc);
        while (mem_resp !== 1'b1 && n < 50) begin @(negedge clk); #2; n++; end
        // Second request already pending while the first is still in RESP.
        push_req(1'b1, 32'h0007_0000, wd, 1'b1);
        mem_action_stb = 1'b1;
        mem_action_cyc = 1'b1;
        mem_write      = 1'b1;
        mem_address    = 32'h0007_0000;
        mem_wdata      = wd;
        @(posedge clk); #2;
        checks++;
        if (pmem_cyc !== 1'b0 || mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap got cyc=%b resp=%b want 0 0", pmem_cyc, mem_resp);
        end
        @(posedge clk); #2;
        checks++;
        if (pmem_stb !== 1'b1 || pmem_we !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got stb=%b we=%b want 1 1", pmem_stb, pmem_we);
        end
        @(negedge clk);
        mem_action_stb = 1'b0;
        wait_done();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_retry();
        test_ack_retry_both();
        test_cyc_drop();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t want finish", $time);
        $fatal(1, "watchdog");
    end
endmodule
